// File: rtl/conv_kernel_mac.sv
// conv_kernel_mac: 5x5 convolution-window MAC.
// The window is fed as five pixel columns, and each column is multiplied by
// five weights read from an external ROM. A kernel bias is added, the result
// is rescaled to Q8.8 and saturated to 16 bits.
// Optional feature: define CONV_MAC_RELU_EN to clamp negative results to zero.
module conv_kernel_mac (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        start,
    input  logic [4:0]  kernel_idx,
    input  logic        pix_vld,
    input  logic [15:0] pix_h0,
    input  logic [15:0] pix_h1,
    input  logic [15:0] pix_h2,
    input  logic [15:0] pix_h3,
    input  logic [15:0] pix_h4,
    output logic [7:0]  param_rd_addr,
    output logic [4:0]  conv_cnt,
    input  logic [15:0] param_w_h0,
    input  logic [15:0] param_w_h1,
    input  logic [15:0] param_w_h2,
    input  logic [15:0] param_w_h3,
    input  logic [15:0] param_w_h4,
    input  logic [15:0] param_bias,
    output logic        busy,
    output logic [15:0] res_data,
    output logic        res_vld
);

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 38;
    localparam int unsigned CW    = 3;
    localparam int unsigned ADW   = 8;
    localparam int unsigned NROW  = 5;
    localparam int unsigned FRAC  = 8;

    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          col;
    logic signed [AW-1:0]   acc;
    logic                   align;
    logic signed [DW-1:0]   pix_q   [NROW];
    logic signed [DW-1:0]   pix_in  [NROW];
    logic signed [DW-1:0]   w_in    [NROW];

    logic signed [AW-1:0]   prod_sum_c;
    logic signed [AW-1:0]   acc_sum_c;
    logic signed [AW-1:0]   biased_c;
    logic signed [AW-1:0]   shifted_c;
    logic [DW-1:0]          result_c;

    assign pix_in[0] = pix_h0;
    assign pix_in[1] = pix_h1;
    assign pix_in[2] = pix_h2;
    assign pix_in[3] = pix_h3;
    assign pix_in[4] = pix_h4;

    assign w_in[0] = param_w_h0;
    assign w_in[1] = param_w_h1;
    assign w_in[2] = param_w_h2;
    assign w_in[3] = param_w_h3;
    assign w_in[4] = param_w_h4;

    // Weight ROM address follows the column that is about to be accepted
    assign param_rd_addr = ADW'(conv_cnt) * ADW'(5) + ADW'(col);

    // Column dot product, accumulation, bias, rescale and saturation
    always_comb begin
        prod_sum_c = '0;
        for (int i = 0; i < NROW; i++) begin
            prod_sum_c = prod_sum_c + AW'(pix_q[i] * w_in[i]);
        end
        acc_sum_c = align ? (acc + prod_sum_c) : acc;
        biased_c  = acc_sum_c + (AW'($signed(param_bias)) <<< FRAC);
        shifted_c = biased_c >>> FRAC;
        if (shifted_c > SAT_MAX) begin
            result_c = DW'(SAT_MAX);
        end else if (shifted_c < SAT_MIN) begin
            result_c = DW'(SAT_MIN);
        end else begin
            result_c = DW'(shifted_c);
        end
`ifdef CONV_MAC_RELU_EN
        if (result_c[DW-1]) begin
            result_c = '0;
        end
`else
`endif
    end

    // Window sequencer: state, counters, pixel capture and result register
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state    <= ST_IDLE;
            conv_cnt <= '0;
            col      <= '0;
            acc      <= '0;
            align    <= 1'b0;
            busy     <= 1'b0;
            res_vld  <= 1'b0;
            res_data <= '0;
            for (int i = 0; i < NROW; i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            res_vld <= 1'b0;
            align   <= 1'b0;
            acc     <= acc_sum_c;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        conv_cnt <= kernel_idx;
                        acc      <= '0;
                        col      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pix_vld) begin
                        for (int i = 0; i < NROW; i++) begin
                            pix_q[i] <= pix_in[i];
                        end
                        align <= 1'b1;
                        if (col == CW'(NROW - 1)) begin
                            col   <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    res_data <= result_c;
                    res_vld  <= 1'b1;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_mac.sv
// tb_conv_kernel_mac: scoreboard bench for conv_kernel_mac with a behavioural
// ROM model and an arithmetic reference for each 5x5 window.
module tb_conv_kernel_mac;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic        start;
    logic [4:0]  kernel_idx;
    logic        pix_vld;
    logic [15:0] pix_h [5];
    logic [7:0]  param_rd_addr;
    logic [4:0]  conv_cnt;
    logic [15:0] w_h [5];
    logic [15:0] bias_r;
    logic        busy;
    logic [15:0] res_data;
    logic        res_vld;

    logic [15:0] rom_w [160][5];
    logic [15:0] rom_b [32];
    logic [15:0] win_px [5][5];

    logic [15:0] exp_data [$];
    int          exp_cyc  [$];
    logic [15:0] held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    conv_kernel_mac dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .start         (start),
        .kernel_idx    (kernel_idx),
        .pix_vld       (pix_vld),
        .pix_h0        (pix_h[0]),
        .pix_h1        (pix_h[1]),
        .pix_h2        (pix_h[2]),
        .pix_h3        (pix_h[3]),
        .pix_h4        (pix_h[4]),
        .param_rd_addr (param_rd_addr),
        .conv_cnt      (conv_cnt),
        .param_w_h0    (w_h[0]),
        .param_w_h1    (w_h[1]),
        .param_w_h2    (w_h[2]),
        .param_w_h3    (w_h[3]),
        .param_w_h4    (w_h[4]),
        .param_bias    (bias_r),
        .busy          (busy),
        .res_data      (res_data),
        .res_vld       (res_vld)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // Parameter ROMs with one cycle of read latency
    always @(posedge sclk) begin
        for (int r = 0; r < 5; r++) w_h[r] <= rom_w[param_rd_addr][r];
        bias_r <= rom_b[conv_cnt];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact window sum in wide integers, floor division by 256, clamp
    function automatic logic [15:0] ref_result(input int k);
        longint s = 0;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++)
                s += longint'($signed(win_px[c][r])) * longint'($signed(rom_w[k*5+c][r]));
        s += longint'($signed(rom_b[k])) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CONV_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    // Monitor: every result pulse must match the oldest expectation, in time
    always @(negedge sclk) begin
        if (s_rst) begin
            held = 16'h0000;
        end else if (res_vld) begin
            if (exp_data.size() == 0) begin
                check("unexpected_res_vld", 32'(res_vld), 32'd0);
            end else begin
                held = exp_data.pop_front();
                check("res_data", 32'(res_data), 32'(held));
                check("latency", 32'(cyc), 32'(exp_cyc.pop_front()));
            end
        end else begin
            check("res_hold", 32'(res_data), 32'(held));
        end
    end

    task automatic fill_rom_const(input logic [15:0] w, input logic [15:0] b);
        for (int a = 0; a < 160; a++)
            for (int r = 0; r < 5; r++) rom_w[a][r] = w;
        for (int k = 0; k < 32; k++) rom_b[k] = b;
    endtask

    task automatic fill_rom_rand();
        logic signed [9:0] t;
        for (int a = 0; a < 160; a++)
            for (int r = 0; r < 5; r++) begin
                t = 10'($urandom);
                rom_w[a][r] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(t);
            end
        for (int k = 0; k < 32; k++) begin
            t = 10'($urandom);
            rom_b[k] = 16'(t);
        end
    endtask

    task automatic fill_px_const(input logic [15:0] v);
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++) win_px[c][r] = v;
    endtask

    task automatic fill_px_rand();
        logic signed [11:0] t;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++) begin
                t = 12'($urandom);
                win_px[c][r] = 16'(t);
            end
    endtask

    // Drive one window; gap<0 picks random stall lengths, do_rst aborts after column 3
    task automatic run_window(input int k, input int gap, input bit noise, input bit do_rst);
        int n = 0;
        int g;
        while (busy && n < 30) begin
            @(posedge sclk); #1;
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
        start = 1'b1;
        kernel_idx = 5'(k);
        @(posedge sclk); #1;
        start = 1'b0;
        kernel_idx = 5'($urandom);
        for (int c = 0; c < 5; c++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                pix_vld = 1'b0;
                for (int r = 0; r < 5; r++) pix_h[r] = 16'($urandom);
                start = noise;
                @(negedge sclk);
                check("addr_gap", 32'(param_rd_addr), 32'(k*5 + c));
                @(posedge sclk); #1;
                start = 1'b0;
            end
            pix_vld = 1'b1;
            for (int r = 0; r < 5; r++) pix_h[r] = win_px[c][r];
            @(negedge sclk);
            check("addr", 32'(param_rd_addr), 32'(k*5 + c));
            check("conv_cnt", 32'(conv_cnt), 32'(k));
            @(posedge sclk); #1;
            if (do_rst && c == 2) begin
                pix_vld = 1'b0;
                #2 s_rst = 1'b1;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_res_vld", 32'(res_vld), 32'd0);
                check("rst_res_data", 32'(res_data), 32'd0);
                check("rst_addr", 32'(param_rd_addr), 32'd0);
                check("rst_conv_cnt", 32'(conv_cnt), 32'd0);
                @(posedge sclk); #1;
                s_rst = 1'b0;
                return;
            end
            if (c == 4) begin
                exp_data.push_back(ref_result(k));
                exp_cyc.push_back(cyc + 1);
            end
        end
        pix_vld = noise;
        for (int r = 0; r < 5; r++) pix_h[r] = 16'($urandom);
        @(posedge sclk); #1;
        start = noise;
        @(posedge sclk); #1;
        start = 1'b0;
        pix_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        s_rst = 1'b1;
        start = 1'b0;
        pix_vld = 1'b0;
        kernel_idx = '0;
        for (int r = 0; r < 5; r++) pix_h[r] = '0;
        held = 16'h0000;
        fill_rom_const(16'h0100, 16'h0000);
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_res_vld", 32'(res_vld), 32'd0);
        check("reset_res_data", 32'(res_data), 32'd0);
        check("reset_addr", 32'(param_rd_addr), 32'd0);
        check("reset_conv_cnt", 32'(conv_cnt), 32'd0);
        @(posedge sclk); #1;
        s_rst = 1'b0;

        // Unit weights and pixels: 25 * 1.0
        fill_px_const(16'h0100);
        run_window(0, 0, 1'b0, 1'b0);
        check("unit_window", 32'(res_data), 32'h1900);

        // Kernel 3 with bias 0.5
        rom_b[3] = 16'h0080;
        run_window(3, 0, 1'b0, 1'b0);
        check("kernel3_bias", 32'(res_data), 32'h1980);

        // Saturation both ways
        fill_rom_const(16'h7FFF, 16'h0000);
        fill_px_const(16'h7FFF);
        run_window(17, 0, 1'b0, 1'b0);
        check("sat_pos", 32'(res_data), 32'h7FFF);
        fill_px_const(16'h8000);
        run_window(31, 0, 1'b0, 1'b0);
`ifdef CONV_MAC_RELU_EN
        check("sat_neg", 32'(res_data), 32'h0000);
`else
        check("sat_neg", 32'(res_data), 32'h8000);
`endif

        // Stalls of 1 and 3 cycles between columns
        fill_rom_const(16'h0100, 16'h0000);
        fill_px_const(16'h0100);
        run_window(0, 1, 1'b0, 1'b0);
        check("gap1_window", 32'(res_data), 32'h1900);
        run_window(0, 3, 1'b0, 1'b0);
        check("gap3_window", 32'(res_data), 32'h1900);

        // Reset mid-window, then a clean window
        run_window(5, 0, 1'b0, 1'b1);
        run_window(0, 0, 1'b0, 1'b0);
        check("post_reset_window", 32'(res_data), 32'h1900);

        // Spurious start in RUN and pix_vld in DRAIN/OUT
        run_window(0, 2, 1'b1, 1'b0);
        check("noise_window", 32'(res_data), 32'h1900);

        // Randomized windows
        for (int i = 0; i < 25; i++) begin
            fill_rom_rand();
            fill_px_rand();
            run_window(int'($urandom_range(0, 31)), -1, 1'($urandom), 1'b0);
        end

        repeat (5) @(posedge sclk);
        #1;
        check("queue_empty", 32'(exp_data.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
